comma_word_aligner: RTL and testbench

Sits directly downstream of the PMA receive path (CDR + serial-to-parallel), in the recovered word-clock domain. Consumes unaligned 10-bit words, hunts for K28.5 commas at every one of the 10 bit offsets across a two-word window, and locks the word boundary after repeated commas at one offset. Emits boundary-aligned 10-bit symbols, a comma flag and a lock indication to the 8b/10b decoder and elastic buffer that follow.

---
 rtl/comma_word_aligner_if.sv | 32 +++
 rtl/comma_word_aligner.sv | 168 ++++++++++++++++
 tb/tb_comma_word_aligner.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/comma_word_aligner_if.sv
// -----------------------------------------------------------------------------
// comma_word_aligner_if
// Bundles the word-stream signals between the PMA receive path, the comma word
// aligner and the 8b/10b decoder that follows it.
//   Data_in        unaligned 10-bit word from the PMA, bit0 = first received bit
//   Data_in_valid  Data_in qualifier
//   Data_out       boundary-aligned symbol, bit0 = bit a of abcdeifghj
//   Data_out_valid Data_out qualifier
//   K285           Data_out is a K28.5 comma (either running disparity)
//   Aligned        word boundary locked
//   Align_offset   bit offset currently applied (0..9)
// master drives the unaligned stream (PMA side / testbench); slave is the aligner.
// -----------------------------------------------------------------------------
interface comma_word_aligner_if;
   logic [9:0] Data_in;
   logic       Data_in_valid;
   logic [9:0] Data_out;
   logic       Data_out_valid;
   logic       K285;
   logic       Aligned;
   logic [3:0] Align_offset;

   modport master (
      output Data_in, Data_in_valid,
      input  Data_out, Data_out_valid, K285, Aligned, Align_offset
   );

   modport slave (
      input  Data_in, Data_in_valid,
      output Data_out, Data_out_valid, K285, Aligned, Align_offset
   );
endinterface

// File: rtl/comma_word_aligner.sv
// -----------------------------------------------------------------------------
// comma_word_aligner
// Hunts for K28.5 commas at all 10 bit offsets of a two-word window built from
// the current and previous valid PMA words, locks the word boundary after
// LOCK_COUNT consecutive commas at one offset and drops lock after LOSS_COUNT
// consecutive commas at a foreign offset. Output latency is one cycle from the
// valid input word.
// Ports:
//   CLK  word clock, all logic on posedge
//   Rst  synchronous active-high reset
//   bus  comma_word_aligner_if.slave (Data_in/valid in; Data_out/valid, K285,
//        Aligned, Align_offset out)
// Parameters:
//   DATA_WIDTH  symbol width, only 10 is supported
//   LOCK_COUNT  consecutive same-offset commas needed to lock (1..15)
//   LOSS_COUNT  consecutive foreign-offset commas needed to drop lock (1..15)
// -----------------------------------------------------------------------------
module comma_word_aligner #(
   parameter int DATA_WIDTH = 10,
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 4
) (
   input  logic                 CLK,
   input  logic                 Rst,
   comma_word_aligner_if.slave  bus
);

   localparam logic [DATA_WIDTH-1:0] COMMA_NEG = 10'h17C;  // K28.5, RD-
   localparam logic [DATA_WIDTH-1:0] COMMA_POS = 10'h283;  // K28.5, RD+
   localparam logic [3:0]            LOCK_TH   = 4'(LOCK_COUNT);
   localparam logic [3:0]            LOSS_TH   = 4'(LOSS_COUNT);

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_CHECK,
      ST_LOCKED
   } state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   prev_q;
   logic [3:0]              cnt_q, cnt_d;
   logic [3:0]              miss_q, miss_d;
   logic [3:0]              off_q, off_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    dvalid_q;
   logic                    k285_q, k285_d;
   logic                    aligned_q, aligned_d;

   logic [2*DATA_WIDTH-1:0] window;
   logic                    hit;
   logic [3:0]              hit_off;

   function automatic logic is_comma(input logic [DATA_WIDTH-1:0] c);
      return (c == COMMA_NEG) || (c == COMMA_POS);
   endfunction

   // Current word on top, previous valid word below: a symbol straddling the
   // word boundary is visible as one contiguous 10-bit slice.
   assign window = {bus.Data_in, prev_q};

   // Scan from the highest offset down so the lowest matching offset is the
   // one left standing when several slices match.
   // NOTE: every variable written in always_comb gets a default first, otherwise
   // a path that skips the assignment infers a latch.
   always_comb begin
      hit     = 1'b0;
      hit_off = 4'd0;
      for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
         if (is_comma(window[k +: DATA_WIDTH])) begin
            hit     = 1'b1;
            hit_off = 4'(k);
         end
      end
   end

   // Lock FSM next state; only valid words carrying a comma move it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      off_d   = off_q;

      if (bus.Data_in_valid && hit) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               off_d   = hit_off;
               cnt_d   = 4'd1;
               miss_d  = 4'd0;
               state_d = (LOCK_TH <= 4'd1) ? ST_LOCKED : ST_CHECK;
            end
            ST_CHECK: begin
               if (hit_off == off_q) begin
                  cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                  if (cnt_d >= LOCK_TH) begin
                     state_d = ST_LOCKED;
                     miss_d  = 4'd0;
                  end
               end else begin
                  // Restart the count at the newly seen offset.
                  off_d = hit_off;
                  cnt_d = 4'd1;
               end
            end
            ST_LOCKED: begin
               if (hit_off == off_q) begin
                  miss_d = 4'd0;
               end else begin
                  miss_d = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
                  if (miss_d >= LOSS_TH) begin
                     // Offset is kept; the next comma re-seeds it anyway.
                     state_d = ST_UNLOCKED;
                     cnt_d   = 4'd0;
                     miss_d  = 4'd0;
                  end
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
   end

   // Output slice uses the offset after this cycle's update, so the word that
   // completes lock already leaves aligned.
   always_comb begin
      dout_d = dout_q;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         if (off_d == 4'(k)) dout_d = window[k +: DATA_WIDTH];
      end
      k285_d    = is_comma(dout_d);
      aligned_d = (state_d == ST_LOCKED);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_q   <= ST_UNLOCKED;
         prev_q    <= '0;
         cnt_q     <= 4'd0;
         miss_q    <= 4'd0;
         off_q     <= 4'd0;
         dout_q    <= '0;
         dvalid_q  <= 1'b0;
         k285_q    <= 1'b0;
         aligned_q <= 1'b0;
      end else begin
         dvalid_q <= bus.Data_in_valid;
         // Invalid cycles freeze everything except the output qualifier.
         if (bus.Data_in_valid) begin
            prev_q    <= bus.Data_in;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            off_q     <= off_d;
            dout_q    <= dout_d;
            k285_q    <= k285_d;
            aligned_q <= aligned_d;
         end
      end
   end

   assign bus.Data_out       = dout_q;
   assign bus.Data_out_valid = dvalid_q;
   assign bus.K285           = k285_q;
   assign bus.Aligned        = aligned_q;
   assign bus.Align_offset   = off_q;

endmodule

// File: tb/tb_comma_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_comma_word_aligner
// Builds a serial bit stream from symbols, slices it into 10-bit PMA words at
// an arbitrary bit phase and compares every output cycle of the aligner
// against a behavioural model of the alignment rules. Directed scenarios add
// fixed expectations for lock/loss points and applied offsets.
// -----------------------------------------------------------------------------
module tb_comma_word_aligner;
   localparam int LOCK_N = 3;
   localparam int LOSS_N = 4;
   localparam logic [9:0] C_NEG = 10'h17C;
   localparam logic [9:0] C_POS = 10'h283;

   logic CLK = 1'b0;
   logic Rst = 1'b1;
   always #5 CLK = ~CLK;

   comma_word_aligner_if bus ();

   comma_word_aligner #(
      .DATA_WIDTH (10),
      .LOCK_COUNT (LOCK_N),
      .LOSS_COUNT (LOSS_N)
   ) dut (
      .CLK (CLK),
      .Rst (Rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model -----------------------------------------
   logic [9:0] m_prev;
   bit         m_locked;
   int         m_cnt, m_miss, m_off;
   logic [9:0] e_out;
   bit         e_valid, e_k, e_al;

   function automatic bit is_comma(input logic [9:0] w);
      return (w == C_NEG) || (w == C_POS);
   endfunction

   task automatic model_reset();
      m_prev = '0; m_locked = 0; m_cnt = 0; m_miss = 0; m_off = 0;
      e_out = '0; e_valid = 0; e_k = 0; e_al = 0;
   endtask

   task automatic model_word(input bit v, input logic [9:0] d);
      logic [19:0] win;
      int k;
      if (!v) begin
         e_valid = 0;
         return;
      end
      win = {d, m_prev};
      k = -1;
      for (int i = 0; i < 10; i++)
         if (k < 0 && is_comma(win[i +: 10])) k = i;
      m_prev = d;
      if (k >= 0) begin
         if (m_locked) begin
            if (k == m_off) m_miss = 0;
            else begin
               if (m_miss < 15) m_miss++;
               if (m_miss >= LOSS_N) begin
                  m_locked = 0; m_cnt = 0; m_miss = 0;
               end
            end
         end else if (m_cnt > 0 && k == m_off) begin
            if (m_cnt < 15) m_cnt++;
            if (m_cnt >= LOCK_N) begin m_locked = 1; m_miss = 0; end
         end else begin
            m_off = k; m_cnt = 1;
            if (LOCK_N <= 1) begin m_locked = 1; m_miss = 0; end
         end
      end
      e_out   = win[m_off +: 10];
      e_k     = is_comma(e_out);
      e_al    = m_locked;
      e_valid = 1;
   endtask

   // ---------------- stimulus helpers -----------------------------------------
   bit bq[$];
   logic [9:0] dsyms [3] = '{10'h155, 10'h2AA, 10'h0A5};

   task automatic push_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) bq.push_back(s[i]);
   endtask

   task automatic push_bits(input int n);
      for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
   endtask

   function automatic logic [9:0] dsym();
      return dsyms[$urandom_range(0, 2)];
   endfunction

   task automatic step(input bit v, input logic [9:0] d);
      bus.Data_in       = d;
      bus.Data_in_valid = v;
      @(posedge CLK);
      model_word(v, d);
      #1;
      check("Data_out_valid", 32'(bus.Data_out_valid), 32'(e_valid));
      check("Data_out", 32'(bus.Data_out), 32'(e_out));
      check("K285", 32'(bus.K285), 32'(e_k));
      check("Aligned", 32'(bus.Aligned), 32'(e_al));
      check("Align_offset", 32'(bus.Align_offset), 32'(m_off));
   endtask

   // Send every complete word in the bit queue, each followed by gmin..gmax
   // invalid cycles.
   task automatic flush(input int gmin, input int gmax);
      logic [9:0] w;
      while (bq.size() >= 10) begin
         for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
         step(1'b1, w);
         repeat ($urandom_range(gmin, gmax)) step(1'b0, 10'($urandom));
      end
   endtask

   // Comma followed by one data symbol so the comma is fully on the wire.
   task automatic send_comma(input logic [9:0] c, input int gap);
      push_sym(c);
      push_sym(dsym());
      flush(gap, gap);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      repeat (2) begin
         bus.Data_in       = 10'($urandom);
         bus.Data_in_valid = 1'($urandom);
         @(posedge CLK);
         #1;
         check("rst Data_out", 32'(bus.Data_out), 32'd0);
         check("rst Data_out_valid", 32'(bus.Data_out_valid), 32'd0);
         check("rst K285", 32'(bus.K285), 32'd0);
         check("rst Aligned", 32'(bus.Aligned), 32'd0);
         check("rst Align_offset", 32'(bus.Align_offset), 32'd0);
      end
      Rst = 1'b0;
      model_reset();
      bq.delete();
   endtask

   // ---------------- scenarios ------------------------------------------------
   initial begin
      bus.Data_in       = '0;
      bus.Data_in_valid = 1'b0;
      model_reset();

      // 1: reset, then comma-free traffic
      do_reset();
      repeat (6) push_sym(dsym());
      flush(0, 0);
      check("t1 Aligned", 32'(bus.Aligned), 32'd0);
      check("t1 Align_offset", 32'(bus.Align_offset), 32'd0);

      // 2: offset 0, D,C,D,D,C,D,C,D
      do_reset();
      push_sym(dsym());
      send_comma(C_NEG, 0);
      push_sym(dsym());
      send_comma(C_NEG, 0);
      check("t2 not yet", 32'(bus.Aligned), 32'd0);
      send_comma(C_NEG, 0);
      check("t2 Aligned", 32'(bus.Aligned), 32'd1);
      check("t2 Align_offset", 32'(bus.Align_offset), 32'd0);

      // 3: same stream shifted by 3 bits, mixed disparity commas
      do_reset();
      push_bits(3);
      push_sym(dsym());
      send_comma(C_NEG, 0);
      push_sym(dsym());
      send_comma(C_POS, 0);
      send_comma(C_NEG, 0);
      check("t3 Aligned", 32'(bus.Aligned), 32'd1);
      check("t3 Align_offset", 32'(bus.Align_offset), 32'd3);
      send_comma(C_POS, 0);
      check("t3 K285 RD+", 32'(bus.Data_out), 32'(C_POS));

      // 4: locked at 3, slip the stream by 4 bits -> commas at 7
      push_bits(4);
      repeat (LOSS_N - 1) send_comma(C_NEG, 0);
      check("t4 still locked", 32'(bus.Aligned), 32'd1);
      check("t4 offset kept", 32'(bus.Align_offset), 32'd3);
      send_comma(C_POS, 0);
      check("t4 lock lost", 32'(bus.Aligned), 32'd0);
      repeat (LOCK_N) send_comma(C_NEG, 0);
      check("t4 relocked", 32'(bus.Aligned), 32'd1);
      check("t4 new offset", 32'(bus.Align_offset), 32'd7);

      // 5a: 5-cycle valid gaps between words
      do_reset();
      push_bits(6);
      send_comma(C_NEG, 5);
      send_comma(C_NEG, 5);
      check("t5 two commas", 32'(bus.Aligned), 32'd0);
      send_comma(C_NEG, 5);
      check("t5 three commas", 32'(bus.Aligned), 32'd1);
      check("t5 gap valid low", 32'(bus.Data_out_valid), 32'd0);

      // 5b: commas at 2,2 then 5,5,5
      do_reset();
      push_bits(2);
      send_comma(C_NEG, 0);
      send_comma(C_NEG, 0);
      push_bits(3);
      send_comma(C_NEG, 0);
      send_comma(C_NEG, 0);
      check("t5b before 5th", 32'(bus.Aligned), 32'd0);
      send_comma(C_NEG, 0);
      check("t5b Aligned", 32'(bus.Aligned), 32'd1);
      check("t5b Align_offset", 32'(bus.Align_offset), 32'd5);

      // 6: reset after 2 of 3 commas discards progress
      do_reset();
      send_comma(C_NEG, 0);
      send_comma(C_NEG, 0);
      do_reset();
      send_comma(C_NEG, 0);
      send_comma(C_NEG, 0);
      check("t6 no early lock", 32'(bus.Aligned), 32'd0);
      send_comma(C_NEG, 0);
      check("t6 lock", 32'(bus.Aligned), 32'd1);

      // 7: randomized mix of commas, raw words, bit slips and gaps
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3)      push_sym($urandom_range(0, 1) ? C_NEG : C_POS);
         else if (r < 5) push_sym(10'($urandom));
         else if (r < 9) push_sym(dsym());
         else            push_bits($urandom_range(1, 9));
         flush(0, 2);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
